cr_cp0_lpmd_mc: RTL and testbench
=================================

# cr_cp0_lpmd_mc

Parametrised multi-mode low-power controller in CP0 for the E902-class core. It sequences a retiring low-power instruction through a per-unit request/acknowledge handshake with `ACK_NUM` quiescing units. It then drives the WAIT/DOZE/STOP code to sysio and gates the core clock. On wake-up it holds the core clock off for a programmable settle delay before releasing the pipeline stall.

## Interface
Parameters:
- `ACK_NUM`, default 2: number of units (IFU, cache, …) that must acknowledge before entry.
- `WAKE_DLY_W`, default 4: width of the wake-settle counter.

Ports (clock and reset are the only decided items: one clock, asynchronous active-low reset):
- `forever_cpuclk` in 1: the single, ungated clock.
- `cpurst_b` in 1: asynchronous, active-low reset.
- `inst_lpmd` in 1: one-cycle pulse when the low-power instruction executes.
- `inst_lpmd_mode` in 2: requested lpmd_b code, valid with `inst_lpmd`.
  - 2'b10 = WAIT, 2'b01 = DOZE, 2'b00 = STOP.
  - 2'b11 = no-op.
- `iu_yy_xx_flush` in 1: pipeline flush.
- `iu_cp0_lp_wk_int` in 1: wake-up interrupt pending.
- `had_yy_xx_dbg` in 1: wake source (debug request).
- `iu_yy_xx_dbgon` in 1: wake source (debug on).
- `unit_ack` in ACK_NUM: per-unit acknowledge; may be a pulse or a level.
- `unit_req` out ACK_NUM: per-unit low-power request.
- `sysio_cp0_sys_view_lpmd_b` in 2: system-side view of the lpmd code.
- `wake_dly` in WAKE_DLY_W: settle cycles after wake-up; quasi-static.
- `cp0_sysio_lpmd_b` out 2: registered lpmd code to sysio.
- `cp0_had_lpmd_b` out 2: same value as `cp0_sysio_lpmd_b`.
- `cp0_yy_clk_en` out 1: core clock enable.
- `cp0_ifu_in_lpmd` out 1: core is in low power.
- `lpmd_iui_stall` out 1: stall to the IU.
- `cp0_sysio_ipend_b` out 1: equals `!iu_cp0_lp_wk_int`.
- `cp0_lpmd_clk_en` out 1: module clock-gate enable.
  - Equals `inst_lpmd || state!=IDLE || wake`.

## Operation
- `wake` = `iu_cp0_lp_wk_int | had_yy_xx_dbg | iu_yy_xx_dbgon`.
- `all_ack` = every bit of (`ack_seen | unit_ack`) is set.
- Registers:
  - `state`: IDLE / WFACK / LPMD / WAKE / CPLT.
  - `mode[1:0]`: latched requested mode.
  - `lpmd_b[1:0]`.
  - `ack_seen[ACK_NUM-1:0]`: sticky acknowledges.
  - `cnt[WAKE_DLY_W-1:0]`: wake-settle counter.
- IDLE:
  - `inst_lpmd` with mode≠11 → WFACK; latch `mode`; clear `ack_seen`.
  - Mode 11 is a no-op: stay in IDLE, no stall.
- WFACK:
  - `unit_req[i] = !ack_seen[i]`.
  - `ack_seen[i]` sets when `unit_ack[i]` is high; it stays set.
  - Priority order: flush → IDLE, then wake → CPLT (abort; `lpmd_b` stays 11), then `all_ack` → LPMD with `lpmd_b <= mode`.
- LPMD:
  - Hold until `wake`.
  - On `wake`: → WAKE, `lpmd_b <= 11`, `cnt <= wake_dly`.
  - Flush is ignored.
- WAKE:
  - `cnt` decrements while nonzero.
  - Exit to CPLT when `cnt==0` and `sysio_cp0_sys_view_lpmd_b==11`.
  - Flush is ignored.
- CPLT: unconditionally → IDLE. Flush → IDLE, which is the same result.
- Outputs (combinational from registers):
  - `lpmd_iui_stall` = (IDLE & `inst_lpmd` & mode≠11) | WFACK | LPMD | WAKE.
  - `cp0_yy_clk_en` = 0 in LPMD, 0 in WAKE while `cnt≠0`, 0 whenever sys_view≠11; otherwise 1.
  - `cp0_ifu_in_lpmd` = LPMD | WAKE | (sys_view≠11).
  - `unit_req` = 0 outside WFACK.
- Reset values:
  - `state` = IDLE, `lpmd_b` = 11, `ack_seen` = 0, `cnt` = 0, `mode` = 11.
  - Outputs with sys_view=11 and no inputs active: `unit_req` = 0, `cp0_sysio_lpmd_b` = 11, `cp0_yy_clk_en` = 1, `cp0_ifu_in_lpmd` = 0, `lpmd_iui_stall` = 0.
  - Reset asserted mid-sequence returns all of the above immediately, asynchronously.
- Encodings of unused states decode to IDLE on the next edge.

## Timing
- `inst_lpmd` at cycle 0:
  - `lpmd_iui_stall` is high in cycle 0.
  - WFACK and `unit_req` = all ones in cycle 1.
- `unit_ack[i]` high in cycle k: `unit_req[i]` low from cycle k+1.
- Last acknowledge in cycle k (including the same cycle as another acknowledge):
  - LPMD in cycle k+1.
  - `cp0_sysio_lpmd_b` = mode and `cp0_yy_clk_en` = 0 in cycle k+1.
- Entry latency from `inst_lpmd` with all acknowledges in cycle 1: 2 cycles.
- `wake` in cycle w while in LPMD:
  - WAKE and `lpmd_b` = 11 in cycle w+1.
  - `cp0_yy_clk_en` rises in cycle w+1+`wake_dly` (if sys_view=11).
  - CPLT in cycle w+2+`wake_dly`; stall falls in the same cycle.
- `wake_dly` = 0: WAKE lasts exactly 1 cycle.
- `wake_dly` at its maximum, 2^W−1: no wrap-around; the counter saturates at 0.
- Simultaneous events:
  - Flush and wake together in WFACK: flush wins.
  - `wake` together with `all_ack` in WFACK: abort wins, so no low-power entry.
- sys_view≠11 from outside: forces `cp0_yy_clk_en` = 0 in any state, but does not change `state`.

## Test plan
- ACK_NUM=3, DOZE (01); `unit_ack` pulsed in cycles 2, 4, 4 → LPMD in cycle 5, `cp0_sysio_lpmd_b` = 01, `cp0_yy_clk_en` = 0; `unit_req` bits drop individually in cycles 3, 5, 5.
- In LPMD, `iu_cp0_lp_wk_int` pulsed with `wake_dly` = 5 → `lpmd_b` = 11 next cycle; `cp0_yy_clk_en` = 0 for 5 cycles; stall falls 7 cycles after the wake; state returns to IDLE.
- `wake_dly` = 0 with sys_view held at 10 for 3 cycles after wake → WAKE held 3 cycles; `cp0_ifu_in_lpmd` stays 1 until sys_view = 11.
- In WFACK, `had_yy_xx_dbg` asserted in the same cycle as the final acknowledge → CPLT, `lpmd_b` never leaves 11, `unit_req` = 0.
- `inst_lpmd` with mode 11 → no stall, state stays IDLE; a separate flush in WFACK → IDLE, `ack_seen` cleared, and a new request re-asserts all `unit_req` bits.
- `cpurst_b` asserted while in LPMD with STOP → all outputs return to their reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/cr_cp0_lpmd_mc_if.sv
// Signal bundle between the CP0 low-power controller and its surroundings
// (IU, quiescing units, sysio, debug).
interface cr_cp0_lpmd_mc_if #(
  parameter int ACK_NUM    = 2,
  parameter int WAKE_DLY_W = 4
);
  logic                  i_inst_lpmd;
  logic [1:0]            i_inst_lpmd_mode;
  logic                  i_iu_yy_xx_flush;
  logic                  i_iu_cp0_lp_wk_int;
  logic                  i_had_yy_xx_dbg;
  logic                  i_iu_yy_xx_dbgon;
  logic [ACK_NUM-1:0]    i_unit_ack;
  logic [ACK_NUM-1:0]    o_unit_req;
  logic [1:0]            i_sysio_cp0_sys_view_lpmd_b;
  logic [WAKE_DLY_W-1:0] i_wake_dly;
  logic [1:0]            o_cp0_sysio_lpmd_b;
  logic [1:0]            o_cp0_had_lpmd_b;
  logic                  o_cp0_yy_clk_en;
  logic                  o_cp0_ifu_in_lpmd;
  logic                  o_lpmd_iui_stall;
  logic                  o_cp0_sysio_ipend_b;
  logic                  o_cp0_lpmd_clk_en;

  modport master (
    output i_inst_lpmd, i_inst_lpmd_mode, i_iu_yy_xx_flush, i_iu_cp0_lp_wk_int,
           i_had_yy_xx_dbg, i_iu_yy_xx_dbgon, i_unit_ack,
           i_sysio_cp0_sys_view_lpmd_b, i_wake_dly,
    input  o_unit_req, o_cp0_sysio_lpmd_b, o_cp0_had_lpmd_b, o_cp0_yy_clk_en,
           o_cp0_ifu_in_lpmd, o_lpmd_iui_stall, o_cp0_sysio_ipend_b,
           o_cp0_lpmd_clk_en
  );

  modport slave (
    input  i_inst_lpmd, i_inst_lpmd_mode, i_iu_yy_xx_flush, i_iu_cp0_lp_wk_int,
           i_had_yy_xx_dbg, i_iu_yy_xx_dbgon, i_unit_ack,
           i_sysio_cp0_sys_view_lpmd_b, i_wake_dly,
    output o_unit_req, o_cp0_sysio_lpmd_b, o_cp0_had_lpmd_b, o_cp0_yy_clk_en,
           o_cp0_ifu_in_lpmd, o_lpmd_iui_stall, o_cp0_sysio_ipend_b,
           o_cp0_lpmd_clk_en
  );
endinterface

// File: rtl/cr_cp0_lpmd_mc.sv
// CP0 low-power controller: quiesces ACK_NUM units, drives WAIT/DOZE/STOP to
// sysio, gates the core clock and holds it off for a settle delay on wake-up.
module cr_cp0_lpmd_mc #(
  parameter int ACK_NUM    = 2,
  parameter int WAKE_DLY_W = 4
) (
  input logic               forever_cpuclk,
  input logic               cpurst_b,
  cr_cp0_lpmd_mc_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WFACK = 3'd1,
    ST_LPMD  = 3'd2,
    ST_WAKE  = 3'd3,
    ST_CPLT  = 3'd4
  } state_t;

  localparam logic [1:0]            LPMD_NOP = 2'b11;
  localparam logic [WAKE_DLY_W-1:0] CNT_ONE  = {{(WAKE_DLY_W-1){1'b0}}, 1'b1};
  localparam logic [WAKE_DLY_W-1:0] CNT_ZERO = {WAKE_DLY_W{1'b0}};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_mode;
  logic [1:0]            r_lpmd_b;
  logic [ACK_NUM-1:0]    r_ack_seen;
  logic [WAKE_DLY_W-1:0] r_cnt;

  logic                  w_wake;
  logic                  w_all_ack;
  logic                  w_start;
  logic                  w_sys_busy;
  logic                  w_cnt_zero;
  logic [ACK_NUM-1:0]    w_unit_req;
  logic                  w_stall;
  logic                  w_clk_en;
  logic                  w_in_lpmd;

  assign w_wake     = bus.i_iu_cp0_lp_wk_int | bus.i_had_yy_xx_dbg | bus.i_iu_yy_xx_dbgon;
  assign w_all_ack  = &(r_ack_seen | bus.i_unit_ack);
  assign w_start    = (r_state == ST_IDLE) & bus.i_inst_lpmd & (bus.i_inst_lpmd_mode != LPMD_NOP);
  assign w_sys_busy = (bus.i_sysio_cp0_sys_view_lpmd_b != LPMD_NOP);
  assign w_cnt_zero = (r_cnt == CNT_ZERO);

  // Next state; in WFACK flush beats wake, and wake (abort) beats entry
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_WFACK;
        else         w_state_nxt = ST_IDLE;
      end
      ST_WFACK: begin
        if (bus.i_iu_yy_xx_flush) w_state_nxt = ST_IDLE;
        else if (w_wake)          w_state_nxt = ST_CPLT;
        else if (w_all_ack)       w_state_nxt = ST_LPMD;
        else                      w_state_nxt = ST_WFACK;
      end
      ST_LPMD: begin
        if (w_wake) w_state_nxt = ST_WAKE;
        else        w_state_nxt = ST_LPMD;
      end
      ST_WAKE: begin
        if (w_cnt_zero && !w_sys_busy) w_state_nxt = ST_CPLT;
        else                           w_state_nxt = ST_WAKE;
      end
      ST_CPLT: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)    r_mode <= LPMD_NOP;
    else if (w_start) r_mode <= bus.i_inst_lpmd_mode;
    else              r_mode <= r_mode;
  end

  // Acknowledges are sticky only while waiting; any other state clears them
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)                r_ack_seen <= {ACK_NUM{1'b0}};
    else if (r_state == ST_WFACK) r_ack_seen <= r_ack_seen | bus.i_unit_ack;
    else                          r_ack_seen <= {ACK_NUM{1'b0}};
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)
      r_lpmd_b <= LPMD_NOP;
    else if ((r_state == ST_WFACK) && (w_state_nxt == ST_LPMD))
      r_lpmd_b <= r_mode;
    else if ((r_state == ST_LPMD) && w_wake)
      r_lpmd_b <= LPMD_NOP;
    else
      r_lpmd_b <= r_lpmd_b;
  end

  // Settle counter saturates at zero, so the maximum delay never wraps
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)
      r_cnt <= CNT_ZERO;
    else if ((r_state == ST_LPMD) && w_wake)
      r_cnt <= bus.i_wake_dly;
    else if ((r_state == ST_WAKE) && !w_cnt_zero)
      r_cnt <= r_cnt - CNT_ONE;
    else
      r_cnt <= r_cnt;
  end

  always_comb begin
    w_unit_req = {ACK_NUM{1'b0}};
    w_stall    = w_start;
    w_clk_en   = !w_sys_busy;
    w_in_lpmd  = w_sys_busy;
    case (r_state)
      ST_WFACK: begin
        w_unit_req = ~r_ack_seen;
        w_stall    = 1'b1;
      end
      ST_LPMD: begin
        w_stall   = 1'b1;
        w_clk_en  = 1'b0;
        w_in_lpmd = 1'b1;
      end
      ST_WAKE: begin
        w_stall   = 1'b1;
        w_in_lpmd = 1'b1;
        if (!w_cnt_zero) w_clk_en = 1'b0;
        else             w_clk_en = !w_sys_busy;
      end
      default: w_stall = w_start;
    endcase
  end

  assign bus.o_unit_req          = w_unit_req;
  assign bus.o_lpmd_iui_stall    = w_stall;
  assign bus.o_cp0_yy_clk_en     = w_clk_en;
  assign bus.o_cp0_ifu_in_lpmd   = w_in_lpmd;
  assign bus.o_cp0_sysio_lpmd_b  = r_lpmd_b;
  assign bus.o_cp0_had_lpmd_b    = r_lpmd_b;
  assign bus.o_cp0_sysio_ipend_b = !bus.i_iu_cp0_lp_wk_int;
  assign bus.o_cp0_lpmd_clk_en   = bus.i_inst_lpmd | (r_state != ST_IDLE) | w_wake;

endmodule

// File: tb/tb_cr_cp0_lpmd_mc.sv
// Directed bench for cr_cp0_lpmd_mc with three quiescing units; each cycle's
// inputs are applied 1 ns after the rising edge and outputs checked 1 ns later.
module tb_cr_cp0_lpmd_mc;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  cr_cp0_lpmd_mc_if #(.ACK_NUM(3), .WAKE_DLY_W(4)) bus ();

  cr_cp0_lpmd_mc #(.ACK_NUM(3), .WAKE_DLY_W(4)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.i_inst_lpmd        = 1'b0;
    bus.i_inst_lpmd_mode   = 2'b11;
    bus.i_iu_yy_xx_flush   = 1'b0;
    bus.i_iu_cp0_lp_wk_int = 1'b0;
    bus.i_had_yy_xx_dbg    = 1'b0;
    bus.i_iu_yy_xx_dbgon   = 1'b0;
    bus.i_unit_ack         = 3'b000;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (bus.o_unit_req !== 3'b000) begin n_fail++; $display("FAIL rst_req got=%b exp=000", bus.o_unit_req); end
    n_checks++; if (bus.o_cp0_sysio_lpmd_b !== 2'b11) begin n_fail++; $display("FAIL rst_lpmd_b got=%b exp=11", bus.o_cp0_sysio_lpmd_b); end
    n_checks++; if (bus.o_cp0_had_lpmd_b !== 2'b11) begin n_fail++; $display("FAIL rst_had_lpmd_b got=%b exp=11", bus.o_cp0_had_lpmd_b); end
    n_checks++; if (bus.o_cp0_yy_clk_en !== 1'b1) begin n_fail++; $display("FAIL rst_clk_en got=%b exp=1", bus.o_cp0_yy_clk_en); end
    n_checks++; if (bus.o_cp0_ifu_in_lpmd !== 1'b0) begin n_fail++; $display("FAIL rst_in_lpmd got=%b exp=0", bus.o_cp0_ifu_in_lpmd); end
    n_checks++; if (bus.o_lpmd_iui_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%b exp=0", bus.o_lpmd_iui_stall); end
    n_checks++; if (bus.o_cp0_sysio_ipend_b !== 1'b1) begin n_fail++; $display("FAIL rst_ipend_b got=%b exp=1", bus.o_cp0_sysio_ipend_b); end
    n_checks++; if (bus.o_cp0_lpmd_clk_en !== 1'b0) begin n_fail++; $display("FAIL rst_lpmd_clk_en got=%b exp=0", bus.o_cp0_lpmd_clk_en); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_nop();
    bus.i_inst_lpmd = 1'b1; bus.i_inst_lpmd_mode = 2'b11;
    #1;
    n_checks++; if (bus.o_lpmd_iui_stall !== 1'b0) begin n_fail++; $display("FAIL nop_stall got=%b exp=0", bus.o_lpmd_iui_stall); end
    n_checks++; if (bus.o_cp0_lpmd_clk_en !== 1'b1) begin n_fail++; $display("FAIL nop_gate_en got=%b exp=1", bus.o_cp0_lpmd_clk_en); end
    step(); clr(); #1;
    n_checks++; if (bus.o_cp0_lpmd_clk_en !== 1'b0) begin n_fail++; $display("FAIL nop_idle got=%b exp=0", bus.o_cp0_lpmd_clk_en); end
    n_checks++; if (bus.o_unit_req !== 3'b000) begin n_fail++; $display("FAIL nop_req got=%b exp=000", bus.o_unit_req); end
  endtask

  task automatic test_doze_entry();
    step(); bus.i_inst_lpmd = 1'b1; bus.i_inst_lpmd_mode = 2'b01; #1;
    n_checks++; if (bus.o_lpmd_iui_stall !== 1'b1) begin n_fail++; $display("FAIL doze_c0_stall got=%b exp=1", bus.o_lpmd_iui_stall); end
    step(); clr(); #1;
    n_checks++; if (bus.o_unit_req !== 3'b111) begin n_fail++; $display("FAIL doze_c1_req got=%b exp=111", bus.o_unit_req); end
    step(); bus.i_unit_ack = 3'b001; #1;
    n_checks++; if (bus.o_unit_req !== 3'b111) begin n_fail++; $display("FAIL doze_c2_req got=%b exp=111", bus.o_unit_req); end
    step(); bus.i_unit_ack = 3'b000; #1;
    n_checks++; if (bus.o_unit_req !== 3'b110) begin n_fail++; $display("FAIL doze_c3_req got=%b exp=110", bus.o_unit_req); end
    step(); bus.i_unit_ack = 3'b110; #1;
    n_checks++; if (bus.o_cp0_sysio_lpmd_b !== 2'b11) begin n_fail++; $display("FAIL doze_c4_lpmd_b got=%b exp=11", bus.o_cp0_sysio_lpmd_b); end
    step(); bus.i_unit_ack = 3'b000; #1;
    n_checks++; if (bus.o_cp0_sysio_lpmd_b !== 2'b01) begin n_fail++; $display("FAIL doze_c5_lpmd_b got=%b exp=01", bus.o_cp0_sysio_lpmd_b); end
    n_checks++; if (bus.o_cp0_had_lpmd_b !== 2'b01) begin n_fail++; $display("FAIL doze_c5_had got=%b exp=01", bus.o_cp0_had_lpmd_b); end
    n_checks++; if (bus.o_cp0_yy_clk_en !== 1'b0) begin n_fail++; $display("FAIL doze_c5_clk_en got=%b exp=0", bus.o_cp0_yy_clk_en); end
    n_checks++; if (bus.o_cp0_ifu_in_lpmd !== 1'b1) begin n_fail++; $display("FAIL doze_c5_in_lpmd got=%b exp=1", bus.o_cp0_ifu_in_lpmd); end
    n_checks++; if (bus.o_unit_req !== 3'b000) begin n_fail++; $display("FAIL doze_c5_req got=%b exp=000", bus.o_unit_req); end
  endtask

  task automatic test_wake_settle();
    bus.i_wake_dly = 4'd5;
    step(); bus.i_iu_cp0_lp_wk_int = 1'b1; #1;
    n_checks++; if (bus.o_cp0_sysio_ipend_b !== 1'b0) begin n_fail++; $display("FAIL wk_ipend_b got=%b exp=0", bus.o_cp0_sysio_ipend_b); end
    for (int i = 1; i <= 5; i++) begin
      step(); clr(); #1;
      n_checks++; if (bus.o_cp0_yy_clk_en !== 1'b0) begin n_fail++; $display("FAIL wk_settle_clk_en cyc=%0d got=%b exp=0", i, bus.o_cp0_yy_clk_en); end
      n_checks++; if (bus.o_lpmd_iui_stall !== 1'b1) begin n_fail++; $display("FAIL wk_settle_stall cyc=%0d got=%b exp=1", i, bus.o_lpmd_iui_stall); end
      if (i == 1) begin
        n_checks++; if (bus.o_cp0_sysio_lpmd_b !== 2'b11) begin n_fail++; $display("FAIL wk_lpmd_b got=%b exp=11", bus.o_cp0_sysio_lpmd_b); end
      end
    end
    step(); #1;
    n_checks++; if (bus.o_cp0_yy_clk_en !== 1'b1) begin n_fail++; $display("FAIL wk_c6_clk_en got=%b exp=1", bus.o_cp0_yy_clk_en); end
    n_checks++; if (bus.o_lpmd_iui_stall !== 1'b1) begin n_fail++; $display("FAIL wk_c6_stall got=%b exp=1", bus.o_lpmd_iui_stall); end
    step(); #1;
    n_checks++; if (bus.o_lpmd_iui_stall !== 1'b0) begin n_fail++; $display("FAIL wk_c7_stall got=%b exp=0", bus.o_lpmd_iui_stall); end
    n_checks++; if (bus.o_cp0_lpmd_clk_en !== 1'b1) begin n_fail++; $display("FAIL wk_c7_cplt got=%b exp=1", bus.o_cp0_lpmd_clk_en); end
    step(); #1;
    n_checks++; if (bus.o_cp0_lpmd_clk_en !== 1'b0) begin n_fail++; $display("FAIL wk_c8_idle got=%b exp=0", bus.o_cp0_lpmd_clk_en); end
  endtask

  task automatic test_sysview();
    bus.i_wake_dly = 4'd0;
    step(); bus.i_sysio_cp0_sys_view_lpmd_b = 2'b01; #1;
    n_checks++; if (bus.o_cp0_yy_clk_en !== 1'b0) begin n_fail++; $display("FAIL sv_idle_clk_en got=%b exp=0", bus.o_cp0_yy_clk_en); end
    n_checks++; if (bus.o_cp0_ifu_in_lpmd !== 1'b1) begin n_fail++; $display("FAIL sv_idle_in_lpmd got=%b exp=1", bus.o_cp0_ifu_in_lpmd); end
    n_checks++; if (bus.o_cp0_lpmd_clk_en !== 1'b0) begin n_fail++; $display("FAIL sv_idle_state got=%b exp=0", bus.o_cp0_lpmd_clk_en); end
    step(); bus.i_sysio_cp0_sys_view_lpmd_b = 2'b11; bus.i_inst_lpmd = 1'b1; bus.i_inst_lpmd_mode = 2'b10; #1;
    n_checks++; if (bus.o_cp0_yy_clk_en !== 1'b1) begin n_fail++; $display("FAIL sv_c0_clk_en got=%b exp=1", bus.o_cp0_yy_clk_en); end
    step(); clr(); bus.i_unit_ack = 3'b111; #1;
    step(); bus.i_unit_ack = 3'b000; #1;
    n_checks++; if (bus.o_cp0_sysio_lpmd_b !== 2'b10) begin n_fail++; $display("FAIL sv_wait_lpmd_b got=%b exp=10", bus.o_cp0_sysio_lpmd_b); end
    n_checks++; if (bus.o_cp0_yy_clk_en !== 1'b0) begin n_fail++; $display("FAIL sv_wait_clk_en got=%b exp=0", bus.o_cp0_yy_clk_en); end
    step(); bus.i_iu_cp0_lp_wk_int = 1'b1; bus.i_sysio_cp0_sys_view_lpmd_b = 2'b10; #1;
    for (int i = 1; i <= 2; i++) begin
      step(); clr(); #1;
      n_checks++; if (bus.o_cp0_ifu_in_lpmd !== 1'b1) begin n_fail++; $display("FAIL sv_hold_in_lpmd cyc=%0d got=%b exp=1", i, bus.o_cp0_ifu_in_lpmd); end
      n_checks++; if (bus.o_cp0_yy_clk_en !== 1'b0) begin n_fail++; $display("FAIL sv_hold_clk_en cyc=%0d got=%b exp=0", i, bus.o_cp0_yy_clk_en); end
      n_checks++; if (bus.o_lpmd_iui_stall !== 1'b1) begin n_fail++; $display("FAIL sv_hold_stall cyc=%0d got=%b exp=1", i, bus.o_lpmd_iui_stall); end
    end
    step(); bus.i_sysio_cp0_sys_view_lpmd_b = 2'b11; #1;
    n_checks++; if (bus.o_lpmd_iui_stall !== 1'b1) begin n_fail++; $display("FAIL sv_c3_stall got=%b exp=1", bus.o_lpmd_iui_stall); end
    n_checks++; if (bus.o_cp0_yy_clk_en !== 1'b1) begin n_fail++; $display("FAIL sv_c3_clk_en got=%b exp=1", bus.o_cp0_yy_clk_en); end
    step(); #1;
    n_checks++; if (bus.o_lpmd_iui_stall !== 1'b0) begin n_fail++; $display("FAIL sv_c4_stall got=%b exp=0", bus.o_lpmd_iui_stall); end
    n_checks++; if (bus.o_cp0_ifu_in_lpmd !== 1'b0) begin n_fail++; $display("FAIL sv_c4_in_lpmd got=%b exp=0", bus.o_cp0_ifu_in_lpmd); end
    step();
  endtask

  task automatic test_abort();
    step(); bus.i_inst_lpmd = 1'b1; bus.i_inst_lpmd_mode = 2'b01; #1;
    step(); clr(); bus.i_unit_ack = 3'b011; #1;
    n_checks++; if (bus.o_unit_req !== 3'b111) begin n_fail++; $display("FAIL ab_c1_req got=%b exp=111", bus.o_unit_req); end
    step(); bus.i_unit_ack = 3'b100; bus.i_had_yy_xx_dbg = 1'b1; #1;
    n_checks++; if (bus.o_unit_req !== 3'b100) begin n_fail++; $display("FAIL ab_c2_req got=%b exp=100", bus.o_unit_req); end
    step(); clr(); #1;
    n_checks++; if (bus.o_cp0_sysio_lpmd_b !== 2'b11) begin n_fail++; $display("FAIL ab_lpmd_b got=%b exp=11", bus.o_cp0_sysio_lpmd_b); end
    n_checks++; if (bus.o_unit_req !== 3'b000) begin n_fail++; $display("FAIL ab_req got=%b exp=000", bus.o_unit_req); end
    n_checks++; if (bus.o_lpmd_iui_stall !== 1'b0) begin n_fail++; $display("FAIL ab_stall got=%b exp=0", bus.o_lpmd_iui_stall); end
    n_checks++; if (bus.o_cp0_lpmd_clk_en !== 1'b1) begin n_fail++; $display("FAIL ab_cplt got=%b exp=1", bus.o_cp0_lpmd_clk_en); end
    step(); #1;
    n_checks++; if (bus.o_cp0_lpmd_clk_en !== 1'b0) begin n_fail++; $display("FAIL ab_idle got=%b exp=0", bus.o_cp0_lpmd_clk_en); end
  endtask

  task automatic test_flush();
    step(); bus.i_inst_lpmd = 1'b1; bus.i_inst_lpmd_mode = 2'b00; #1;
    step(); clr(); bus.i_unit_ack = 3'b001; #1;
    step(); bus.i_unit_ack = 3'b000; bus.i_iu_yy_xx_flush = 1'b1; bus.i_iu_cp0_lp_wk_int = 1'b1; #1;
    n_checks++; if (bus.o_unit_req !== 3'b110) begin n_fail++; $display("FAIL fl_req got=%b exp=110", bus.o_unit_req); end
    step(); clr(); #1;
    n_checks++; if (bus.o_cp0_lpmd_clk_en !== 1'b0) begin n_fail++; $display("FAIL fl_idle got=%b exp=0", bus.o_cp0_lpmd_clk_en); end
    n_checks++; if (bus.o_lpmd_iui_stall !== 1'b0) begin n_fail++; $display("FAIL fl_stall got=%b exp=0", bus.o_lpmd_iui_stall); end
    step(); bus.i_inst_lpmd = 1'b1; bus.i_inst_lpmd_mode = 2'b00; #1;
    step(); clr(); #1;
    n_checks++; if (bus.o_unit_req !== 3'b111) begin n_fail++; $display("FAIL fl_rereq got=%b exp=111", bus.o_unit_req); end
    bus.i_unit_ack = 3'b111;
    step(); bus.i_unit_ack = 3'b000; #1;
    n_checks++; if (bus.o_cp0_sysio_lpmd_b !== 2'b00) begin n_fail++; $display("FAIL fl_stop_lpmd_b got=%b exp=00", bus.o_cp0_sysio_lpmd_b); end
    step(); bus.i_iu_yy_xx_flush = 1'b1; #1;
    step(); clr(); #1;
    n_checks++; if (bus.o_cp0_sysio_lpmd_b !== 2'b00) begin n_fail++; $display("FAIL fl_lpmd_ignored got=%b exp=00", bus.o_cp0_sysio_lpmd_b); end
    n_checks++; if (bus.o_cp0_yy_clk_en !== 1'b0) begin n_fail++; $display("FAIL fl_lpmd_clk_en got=%b exp=0", bus.o_cp0_yy_clk_en); end
  endtask

  task automatic test_async_reset();
    step(); #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_unit_req !== 3'b000) begin n_fail++; $display("FAIL ar_req got=%b exp=000", bus.o_unit_req); end
    n_checks++; if (bus.o_cp0_sysio_lpmd_b !== 2'b11) begin n_fail++; $display("FAIL ar_lpmd_b got=%b exp=11", bus.o_cp0_sysio_lpmd_b); end
    n_checks++; if (bus.o_cp0_yy_clk_en !== 1'b1) begin n_fail++; $display("FAIL ar_clk_en got=%b exp=1", bus.o_cp0_yy_clk_en); end
    n_checks++; if (bus.o_cp0_ifu_in_lpmd !== 1'b0) begin n_fail++; $display("FAIL ar_in_lpmd got=%b exp=0", bus.o_cp0_ifu_in_lpmd); end
    n_checks++; if (bus.o_lpmd_iui_stall !== 1'b0) begin n_fail++; $display("FAIL ar_stall got=%b exp=0", bus.o_lpmd_iui_stall); end
    n_checks++; if (bus.o_cp0_lpmd_clk_en !== 1'b0) begin n_fail++; $display("FAIL ar_lpmd_clk_en got=%b exp=0", bus.o_cp0_lpmd_clk_en); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clr();
    bus.i_sysio_cp0_sys_view_lpmd_b = 2'b11;
    bus.i_wake_dly = 4'd0;
    #12;
    test_reset();
    test_nop();
    test_doze_entry();
    test_wake_settle();
    test_sysview();
    test_abort();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
